// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle ARM operand-2 shifter, STEP bits per SHIFT cycle.
// Define SHIFT_SEQ_FLUSH_EN to add a flush input that abandons an operation.
module shift_sequencer #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SHIFT_SEQ_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] op_data,
    input  logic [1:0]  shift_type,
    input  logic        amt_src,
    input  logic [4:0]  amt_imm,
    input  logic [7:0]  amt_reg,
    input  logic        imm_mode,
    input  logic [7:0]  imm8,
    input  logic [3:0]  rot4,
    input  logic        carry_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_carry,
    output logic        busy
);

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] work;
    logic [5:0]  remaining;
    logic [1:0]  type_q;
    logic        over32_q;

    logic [7:0]  amt_full;
    logic [31:0] imm_rot;
    logic        cap_special;
    logic [31:0] cap_data;
    logic        cap_carry;
    logic [5:0]  cap_n;
    logic        cap_over32;

    logic [5:0]  step_k;
    logic [31:0] step_data;
    logic        step_carry;
    logic        flush_hit;

    function automatic logic [31:0] ror32(
        input logic [31:0] x,
        input logic [4:0]  amt
    );
        logic [63:0] dbl;
        dbl = {x, x} >> amt;
        return dbl[31:0];
    endfunction

    // Bit-serial inner loop; only the first k of STEP slots are active.
    function automatic logic [32:0] shift_step(
        input logic [31:0] d_in,
        input logic [1:0]  ty,
        input logic [5:0]  k
    );
        logic [31:0] d;
        logic        c;
        d = d_in;
        c = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (6'(i) < k) begin
                unique case (ty)
                    SH_LSL: begin c = d[31]; d = {d[30:0], 1'b0}; end
                    SH_LSR: begin c = d[0];  d = {1'b0, d[31:1]}; end
                    SH_ASR: begin c = d[0];  d = {d[31], d[31:1]}; end
                    default: begin c = d[0]; d = {d[0], d[31:1]}; end
                endcase
            end
        end
        return {c, d};
    endfunction

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        amt_full    = amt_src ? amt_reg : {3'b000, amt_imm};
        imm_rot     = ror32({24'd0, imm8}, {rot4, 1'b0});
        cap_special = 1'b1;
        cap_data    = op_data;
        cap_carry   = carry_in;
        cap_n       = 6'd0;
        cap_over32  = 1'b0;
        if (imm_mode) begin
            cap_data  = imm_rot;
            cap_carry = (rot4 == 4'd0) ? carry_in : imm_rot[31];
        end else if (amt_full == 8'd0) begin
            if (!amt_src && shift_type == SH_ROR) begin
                cap_data  = {carry_in, op_data[31:1]};
                cap_carry = op_data[0];
            end else if (!amt_src && shift_type != SH_LSL) begin
                cap_special = 1'b0;
                cap_n       = 6'd32;
            end
        end else if (amt_src && shift_type == SH_ROR) begin
            if (amt_reg[4:0] == 5'd0) begin
                cap_carry = op_data[31];
            end else begin
                cap_special = 1'b0;
                cap_n       = {1'b0, amt_reg[4:0]};
            end
        end else begin
            cap_special = 1'b0;
            cap_n       = (amt_full > 8'd32) ? 6'd32 : amt_full[5:0];
            cap_over32  = amt_src && (shift_type != SH_ASR)
                          && (amt_full > 8'd32);
        end
    end

    always_comb begin
        step_k = (remaining < 6'(STEP)) ? remaining : 6'(STEP);
        {step_carry, step_data} = shift_step(work, type_q, step_k);
    end

`ifdef SHIFT_SEQ_FLUSH_EN
    assign flush_hit = flush && (state != IDLE);
`else
    assign flush_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= 32'd0;
            remaining <= 6'd0;
            type_q    <= SH_LSL;
            over32_q  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= 32'd0;
            res_carry <= 1'b0;
        end else if (flush_hit) begin
            state     <= IDLE;
            res_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        type_q   <= shift_type;
                        over32_q <= cap_over32;
                        if (cap_special) begin
                            res_data  <= cap_data;
                            res_carry <= cap_carry;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            work      <= op_data;
                            remaining <= cap_n;
                            state     <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work      <= step_data;
                    remaining <= remaining - step_k;
                    if (remaining == step_k) begin
                        res_data  <= step_data;
                        res_carry <= step_carry & ~over32_q;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller for the ARM data-processing operand-2 shifter.
- Accepts one shift request over a valid/ready handshake and iterates the shift STEP bits per cycle.
- Applies ARM special-case encodings: LSR/ASR #0 means #32, ROR #0 means RRX, register amounts of 32 or more.
- Returns the result and shifter carry-out over a second valid/ready handshake; sits between the decode stage and the ALU operand-2 input.

Parameters:
- STEP, 4, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; equals (state==IDLE).
- op_data  in  32  value to shift (Rm).
- shift_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- amt_src  in  1  0: amount from amt_imm; 1: amount from amt_reg.
- amt_imm  in  5  immediate shift amount.
- amt_reg  in  8  register shift amount (Rs[7:0]).
- imm_mode  in  1  1: rotated-immediate operand; ignores op_data, shift_type and the amount inputs.
- imm8  in  8  immediate byte.
- rot4  in  4  rotate field; rotation = 2*rot4.
- carry_in  in  1  current CPSR C flag.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_data  out  32  shifted result.
- res_carry  out  1  shifter carry-out.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (asynchronous, active-low) forces state IDLE, res_valid=0, res_data=0, res_carry=0, busy=0, req_ready=1. Reset mid-operation discards the operation; no partial result is emitted.
- The request is captured on req_valid&req_ready. Every input is sampled only in that cycle.
- States: IDLE -> SHIFT or DONE -> IDLE.
- IDLE, on capture:
  - Compute the effective amount N and the special-case flags.
  - If N>0 and the operation is not special, go to SHIFT with remaining=N and work=op_data.
  - Otherwise compute the result directly and go to DONE.
- Special cases, resolved at capture with zero SHIFT cycles:
  - imm_mode: res = imm8 rotated right by 2*rot4. carry = carry_in when rot4==0, else res[31].
  - Immediate LSL #0, or register amount 0 (any type): res = op_data, carry = carry_in.
  - Immediate ROR #0 (RRX): res = {carry_in, op_data[31:1]}, carry = op_data[0].
  - Register ROR with amt_reg!=0 and amt_reg[4:0]==0: res = op_data, carry = op_data[31].
- Effective amount N:
  - Immediate LSR/ASR #0: N=32.
  - Register ROR: N=amt_reg[4:0].
  - Otherwise: N=min(amount, 32). Set the flag over32 when a register LSL/LSR amount exceeds 32.
- SHIFT: each cycle shift work by k=min(STEP, remaining), then remaining -= k.
  - Fill: LSL and LSR fill with 0; ASR fills with op_data[31]; ROR rotates.
  - Carry register = last bit shifted out (ROR: last bit rotated out of bit 0).
  - When remaining reaches 0, go to DONE.
- DONE: res_valid=1 with res_data=work and res_carry=carry; res_carry is forced to 0 if over32.
  - res_data and res_carry stay stable while res_valid&~res_ready.
  - On res_ready, go to IDLE and drop res_valid.
  - A new request can be accepted in the cycle after the result is taken; there is no overlap.
- Latency, handshake cycle to res_valid:
  - Non-special with N>0: 1 + ceil(N/STEP) cycles.
  - Special cases: 1 cycle.
- Resulting ARM semantics:
  - LSL 32: 0, carry = op_data[0].
  - LSR 32: 0, carry = op_data[31].
  - ASR at or above 32: all sign bits, carry = op_data[31].
  - LSL/LSR above 32: 0, carry 0.

Optional Feature:
- Macro SHIFT_SEQ_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - flush high in SHIFT or DONE returns to IDLE on the next edge, clears res_valid and emits no result.
  - flush in IDLE has no effect.
  - flush coincident with a capture in IDLE does not block the capture.
- Undefined: no flush port; an operation always completes.

Test Plan:
- LSL imm 4, op_data 0xF000000F, STEP=4 -> res 0x000000F0, carry 1, res_valid 2 cycles after the handshake.
- LSR imm 0 (#32), op_data 0x80000001 -> res 0x00000000, carry 1, latency 9 cycles.
- ASR reg amt_reg=40, op_data 0x80000000 -> res 0xFFFFFFFF, carry 1. Repeat with LSR -> res 0, carry 0.
- ROR imm 0 (RRX), op_data 0x00000003, carry_in 1 -> res 0x80000001, carry 1, latency 1 cycle.
- imm_mode, imm8 0xFF, rot4 4 -> res 0xFF000000, carry 1. With rot4 0 and carry_in 0 -> res 0x000000FF, carry 0.
- Hold res_ready low 3 cycles in DONE -> res_valid, res_data and res_carry stable and req_ready 0.
  - Then assert rst_n low mid-SHIFT -> res_valid 0 and req_ready 1 immediately.
  - With the macro defined, flush mid-SHIFT -> no res_valid, back to IDLE on the next edge.
